rv_wb_stage: RTL and testbench
==============================

Name: rv_wb_stage

Overview:
- Writeback stage of the RISC-V pipeline. It directly drives the register file write port: write enable, destination address and write data.
- Accepts retiring instructions from execute over a valid/ready handshake.
- For loads, waits for the data-memory response, then aligns and sign/zero-extends the load data before writing.
- Also exposes the pending-load destination for hazard detection and a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter instret_o (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous active-high reset.
- ex_valid_i  in  1  execute presents an instruction.
- ex_ready_o  out  1  stage can accept; combinational, equals (state==IDLE).
- ex_rd_addr_i  in  5  destination register.
- ex_rd_wr_i  in  1  instruction writes rd.
- ex_is_load_i  in  1  instruction is a load.
- ex_load_size_i  in  2  load size: 00 byte, 01 half, 10 word, 11 illegal.
- ex_load_unsigned_i  in  1  zero-extend (LBU/LHU) instead of sign-extend.
- ex_addr_lo_i  in  2  load byte address [1:0].
- ex_alu_res_i  in  32  result for non-load instructions.
- mem_rsp_valid_i  in  1  load data valid, single-cycle pulse.
- mem_rsp_data_i  in  32  aligned 32-bit memory word.
- rf_wr_en_o  out  1  register file write enable (registered).
- rf_rd_addr_o  out  5  register file write address (registered).
- rf_wr_data_o  out  32  register file write data (registered).
- pend_valid_o  out  1  a load is outstanding.
- pend_rd_o  out  5  rd of the outstanding load.
- instret_o  out  CNT_W  count of retired instructions.
- err_o  out  1  sticky error flag.

Behaviour:
- Reset (synchronous):
  - state=IDLE.
  - rf_wr_en_o=0, rf_rd_addr_o=0, rf_wr_data_o=0.
  - pend_valid_o=0, pend_rd_o=0, instret_o=0, err_o=0.
  - Reset during LOAD_WAIT drops the outstanding load; no write occurs.
- Accept condition: accept = ex_valid_i & ex_ready_o.
- rf_wr_en_o is a one-cycle pulse. rf_rd_addr_o and rf_wr_data_o hold their values until the next write.
- States: IDLE and LOAD_WAIT.
- IDLE, accept of a non-load:
  - Next cycle: rf_wr_en_o = ex_rd_wr_i & (ex_rd_addr_i!=0), rf_rd_addr_o = ex_rd_addr_i, rf_wr_data_o = ex_alu_res_i.
  - instret_o increments. Stay in IDLE.
  - Back-to-back accepts sustain one instruction per cycle.
- IDLE, accept of a misaligned or illegal load:
  - Misaligned means size 01 with addr_lo[0]=1, size 10 with addr_lo!=0, or size 11.
  - err_o is set. No write, no instret increment, stay in IDLE.
- IDLE, accept of a legal load:
  - Latch rd, size, unsigned flag and addr_lo, then go to LOAD_WAIT.
  - pend_valid_o=1 and pend_rd_o=rd from the next cycle onward.
- LOAD_WAIT:
  - ex_ready_o=0.
  - On mem_rsp_valid_i, the next cycle produces:
    - rf_wr_en_o = (rd!=0).
    - rf_wr_data_o = extracted value.
    - instret_o increments.
    - state=IDLE, pend_valid_o=0.
  - ex_ready_o returns to 1 in that same next cycle; there is no same-cycle bypass.
- Load data extraction:
  - Byte: mem_rsp_data_i[8*addr_lo +: 8].
  - Half: addr_lo[1] ? mem_rsp_data_i[31:16] : mem_rsp_data_i[15:0].
  - Word: mem_rsp_data_i unchanged.
  - Byte and half results are extended to 32 bits: replicated MSB if signed, zeros if unsigned.
- Unexpected response: mem_rsp_valid_i while in IDLE sets err_o and is otherwise ignored.
- err_o is cleared only by reset.
- rd=x0: the write is suppressed but the instruction still retires.
- instret_o wraps from all-ones to 0.

Test Plan:
- Reset, then ALU op with rd=5, alu_res=0xDEADBEEF, rd_wr=1 → next cycle rf_wr_en_o=1, rf_rd_addr_o=5, rf_wr_data_o=0xDEADBEEF, instret_o=1.
- 4 back-to-back ALU ops with ex_valid_i held high → ex_ready_o stays 1, four consecutive write pulses, instret_o=4. An op to rd=0 gives no write pulse but still counts.
- LB rd=7 with addr_lo=2; response 3 cycles later with data 0x12805634 → ex_ready_o=0 and pend_valid_o=1, pend_rd_o=7 while waiting; one cycle after the response rf_wr_data_o=0xFFFFFF80 and rf_wr_en_o=1.
- LHU with addr_lo=2 and data 0x8001ABCD → 0x00008001. LW with data 0xCAFEF00D → 0xCAFEF00D.
- LH with addr_lo=1 → err_o=1, no write, stays in IDLE. A later mem_rsp_valid_i while in IDLE keeps err_o=1 and produces no write.
- Legal load accepted, reset asserted one cycle later, then a response arrives → no write, pend_valid_o=0, instret_o=0, err_o=1 from the stray response.

Source files
------------

// File: rtl/rv_wb_stage_if.sv
// Bundle of execute-side handshake, memory response and register-file write
// signals shared by the writeback stage and whoever drives it.
interface rv_wb_stage_if #(
    parameter int CNT_W = 32
);
    logic             ex_valid_i;
    logic             ex_ready_o;
    logic [4:0]       ex_rd_addr_i;
    logic             ex_rd_wr_i;
    logic             ex_is_load_i;
    logic [1:0]       ex_load_size_i;
    logic             ex_load_unsigned_i;
    logic [1:0]       ex_addr_lo_i;
    logic [31:0]      ex_alu_res_i;
    logic             mem_rsp_valid_i;
    logic [31:0]      mem_rsp_data_i;
    logic             rf_wr_en_o;
    logic [4:0]       rf_rd_addr_o;
    logic [31:0]      rf_wr_data_o;
    logic             pend_valid_o;
    logic [4:0]       pend_rd_o;
    logic [CNT_W-1:0] instret_o;
    logic             err_o;

    modport master (
        output ex_valid_i, ex_rd_addr_i, ex_rd_wr_i, ex_is_load_i, ex_load_size_i,
               ex_load_unsigned_i, ex_addr_lo_i, ex_alu_res_i,
               mem_rsp_valid_i, mem_rsp_data_i,
        input  ex_ready_o, rf_wr_en_o, rf_rd_addr_o, rf_wr_data_o,
               pend_valid_o, pend_rd_o, instret_o, err_o
    );

    modport slave (
        input  ex_valid_i, ex_rd_addr_i, ex_rd_wr_i, ex_is_load_i, ex_load_size_i,
               ex_load_unsigned_i, ex_addr_lo_i, ex_alu_res_i,
               mem_rsp_valid_i, mem_rsp_data_i,
        output ex_ready_o, rf_wr_en_o, rf_rd_addr_o, rf_wr_data_o,
               pend_valid_o, pend_rd_o, instret_o, err_o
    );
endinterface

// File: rtl/rv_wb_stage.sv
// RISC-V writeback stage: retires ALU results directly and waits for the
// memory response on loads, aligning and extending the data before the write.
module rv_wb_stage #(
    parameter int CNT_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    rv_wb_stage_if.slave  bus
);
    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] LOAD_WAIT = 1'b1;

    logic [0:0]  state_reg;
    logic [4:0]  ld_rd_reg;
    logic [1:0]  ld_size_reg;
    logic        ld_uns_reg;
    logic [1:0]  ld_lo_reg;

    logic        accept;
    logic        misaligned;
    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    assign bus.ex_ready_o = (state_reg == IDLE);
    assign accept         = bus.ex_valid_i & bus.ex_ready_o;

    assign misaligned = (bus.ex_load_size_i == 2'b01 && bus.ex_addr_lo_i[0]) ||
                        (bus.ex_load_size_i == 2'b10 && bus.ex_addr_lo_i != 2'b00) ||
                        (bus.ex_load_size_i == 2'b11);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = bus.mem_rsp_data_i[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lane[ld_lo_reg];
    assign half_sel = ld_lo_reg[1] ? bus.mem_rsp_data_i[31:16] : bus.mem_rsp_data_i[15:0];

    always_comb begin
        load_val = bus.mem_rsp_data_i;
        case (ld_size_reg)
            2'b00:   load_val = ld_uns_reg ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_val = ld_uns_reg ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_val = bus.mem_rsp_data_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            ld_rd_reg        <= '0;
            ld_size_reg      <= '0;
            ld_uns_reg       <= 1'b0;
            ld_lo_reg        <= '0;
            bus.rf_wr_en_o   <= 1'b0;
            bus.rf_rd_addr_o <= '0;
            bus.rf_wr_data_o <= '0;
            bus.pend_valid_o <= 1'b0;
            bus.pend_rd_o    <= '0;
            bus.instret_o    <= '0;
            bus.err_o        <= 1'b0;
        end else begin
            bus.rf_wr_en_o <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // A response with nothing outstanding is a protocol error.
                    if (bus.mem_rsp_valid_i)
                        bus.err_o <= 1'b1;
                    if (accept) begin
                        if (!bus.ex_is_load_i) begin
                            bus.rf_wr_en_o   <= bus.ex_rd_wr_i & (bus.ex_rd_addr_i != 5'd0);
                            bus.rf_rd_addr_o <= bus.ex_rd_addr_i;
                            bus.rf_wr_data_o <= bus.ex_alu_res_i;
                            bus.instret_o    <= bus.instret_o + {{(CNT_W-1){1'b0}}, 1'b1};
                        end else if (misaligned) begin
                            bus.err_o <= 1'b1;
                        end else begin
                            ld_rd_reg        <= bus.ex_rd_addr_i;
                            ld_size_reg      <= bus.ex_load_size_i;
                            ld_uns_reg       <= bus.ex_load_unsigned_i;
                            ld_lo_reg        <= bus.ex_addr_lo_i;
                            bus.pend_valid_o <= 1'b1;
                            bus.pend_rd_o    <= bus.ex_rd_addr_i;
                            state_reg        <= LOAD_WAIT;
                        end
                    end
                end
                default: begin
                    if (bus.mem_rsp_valid_i) begin
                        bus.rf_wr_en_o   <= (ld_rd_reg != 5'd0);
                        bus.rf_rd_addr_o <= ld_rd_reg;
                        bus.rf_wr_data_o <= load_val;
                        bus.instret_o    <= bus.instret_o + {{(CNT_W-1){1'b0}}, 1'b1};
                        bus.pend_valid_o <= 1'b0;
                        state_reg        <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rv_wb_stage.sv
// Directed, table-driven bench for rv_wb_stage with hand-written sequences
// for back-to-back issue, load errors, stray responses and reset mid-load.
module tb_rv_wb_stage;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    rv_wb_stage_if #(.CNT_W(32)) bus ();

    rv_wb_stage #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_load;
        logic [4:0]  rd;
        logic        rd_wr;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  lo;
        logic [31:0] alu;
        logic [31:0] mem;
        int          delay;
        logic        exp_wen;
        logic [31:0] exp_data;
        logic [31:0] exp_instret;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_op(input logic is_load, input logic [4:0] rd, input logic rd_wr,
                            input logic [1:0] size, input logic uns, input logic [1:0] lo,
                            input logic [31:0] alu);
        bus.ex_valid_i         = 1'b1;
        bus.ex_is_load_i       = is_load;
        bus.ex_rd_addr_i       = rd;
        bus.ex_rd_wr_i         = rd_wr;
        bus.ex_load_size_i     = size;
        bus.ex_load_unsigned_i = uns;
        bus.ex_addr_lo_i       = lo;
        bus.ex_alu_res_i       = alu;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.ex_valid_i = 1'b0;
        drive_op(1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0);
        bus.ex_valid_i      = 1'b0;
        bus.mem_rsp_valid_i = 1'b0;
        bus.mem_rsp_data_i  = 32'h0;

        //            load  rd  wr  size   uns   lo     alu           mem          dly wen   data          instret
        vecs[0] = '{1'b0, 5'd5, 1'b1, 2'b00, 1'b0, 2'b00, 32'hDEADBEEF, 32'h0,       0, 1'b1, 32'hDEADBEEF, 32'd1};
        vecs[1] = '{1'b1, 5'd7, 1'b1, 2'b00, 1'b0, 2'b10, 32'h0,       32'h12805634, 3, 1'b1, 32'hFFFFFF80, 32'd2};
        vecs[2] = '{1'b1, 5'd3, 1'b1, 2'b01, 1'b1, 2'b10, 32'h0,       32'h8001ABCD, 1, 1'b1, 32'h00008001, 32'd3};
        vecs[3] = '{1'b1, 5'd9, 1'b1, 2'b10, 1'b0, 2'b00, 32'h0,       32'hCAFEF00D, 0, 1'b1, 32'hCAFEF00D, 32'd4};
        vecs[4] = '{1'b1, 5'd4, 1'b1, 2'b00, 1'b1, 2'b11, 32'h0,       32'h9A345678, 2, 1'b1, 32'h0000009A, 32'd5};
        vecs[5] = '{1'b1, 5'd6, 1'b1, 2'b01, 1'b0, 2'b00, 32'h0,       32'h1234F00F, 1, 1'b1, 32'hFFFFF00F, 32'd6};
        vecs[6] = '{1'b1, 5'd0, 1'b1, 2'b00, 1'b0, 2'b01, 32'h0,       32'h00007F00, 0, 1'b0, 32'h0000007F, 32'd7};
        vecs[7] = '{1'b0, 5'd8, 1'b0, 2'b00, 1'b0, 2'b00, 32'h00000055, 32'h0,       0, 1'b0, 32'h00000055, 32'd8};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        $display("reset state");
        check("rst_wr_en",   {31'b0, bus.rf_wr_en_o},   32'd0);
        check("rst_rd_addr", {27'b0, bus.rf_rd_addr_o}, 32'd0);
        check("rst_wr_data", bus.rf_wr_data_o,          32'd0);
        check("rst_pend",    {31'b0, bus.pend_valid_o}, 32'd0);
        check("rst_instret", bus.instret_o,             32'd0);
        check("rst_err",     {31'b0, bus.err_o},        32'd0);
        check("rst_ready",   {31'b0, bus.ex_ready_o},   32'd1);

        for (int i = 0; i < 8; i++) begin
            drive_op(vecs[i].is_load, vecs[i].rd, vecs[i].rd_wr, vecs[i].size,
                     vecs[i].uns, vecs[i].lo, vecs[i].alu);
            @(negedge clk);
            bus.ex_valid_i = 1'b0;
            if (vecs[i].is_load) begin
                check("ld_ready_wait", {31'b0, bus.ex_ready_o},   32'd0);
                check("ld_pend_valid", {31'b0, bus.pend_valid_o}, 32'd1);
                check("ld_pend_rd",    {27'b0, bus.pend_rd_o},    {27'b0, vecs[i].rd});
                for (int d = 0; d < vecs[i].delay; d++) begin
                    @(negedge clk);
                    check("ld_wait_ready", {31'b0, bus.ex_ready_o}, 32'd0);
                    check("ld_wait_wen",   {31'b0, bus.rf_wr_en_o}, 32'd0);
                end
                bus.mem_rsp_valid_i = 1'b1;
                bus.mem_rsp_data_i  = vecs[i].mem;
                @(negedge clk);
                bus.mem_rsp_valid_i = 1'b0;
                check("ld_done_ready", {31'b0, bus.ex_ready_o},   32'd1);
                check("ld_done_pend",  {31'b0, bus.pend_valid_o}, 32'd0);
            end
            $display("vec %0d: load=%0d rd=%0d wen=%0d data=0x%08h instret=%0d",
                     i, vecs[i].is_load, vecs[i].rd, bus.rf_wr_en_o, bus.rf_wr_data_o, bus.instret_o);
            check("vec_wen",     {31'b0, bus.rf_wr_en_o},   {31'b0, vecs[i].exp_wen});
            check("vec_addr",    {27'b0, bus.rf_rd_addr_o}, {27'b0, vecs[i].rd});
            check("vec_data",    bus.rf_wr_data_o,          vecs[i].exp_data);
            check("vec_instret", bus.instret_o,             vecs[i].exp_instret);
            @(negedge clk);
            check("vec_wen_pulse", {31'b0, bus.rf_wr_en_o}, 32'd0);
        end

        // Back-to-back ALU ops with valid held high; rd=0 must count but not write.
        begin
            logic [4:0] b2b_rd [4];
            b2b_rd = '{5'd1, 5'd2, 5'd0, 5'd3};
            for (int i = 0; i < 4; i++) begin
                drive_op(1'b0, b2b_rd[i], 1'b1, 2'b00, 1'b0, 2'b00, 32'h1000 + i);
                check("b2b_ready", {31'b0, bus.ex_ready_o}, 32'd1);
                @(negedge clk);
                $display("b2b %0d: rd=%0d wen=%0d data=0x%08h instret=%0d",
                         i, b2b_rd[i], bus.rf_wr_en_o, bus.rf_wr_data_o, bus.instret_o);
                check("b2b_wen",     {31'b0, bus.rf_wr_en_o}, (b2b_rd[i] != 5'd0) ? 32'd1 : 32'd0);
                check("b2b_data",    bus.rf_wr_data_o,        32'h1000 + i);
                check("b2b_instret", bus.instret_o,           32'd9 + i);
            end
            bus.ex_valid_i = 1'b0;
        end

        check("err_clean", {31'b0, bus.err_o}, 32'd0);

        // Misaligned LH: flag error, no write, no retire, remain ready.
        drive_op(1'b1, 5'd10, 1'b1, 2'b01, 1'b0, 2'b01, 32'h0);
        @(negedge clk);
        bus.ex_valid_i = 1'b0;
        $display("misaligned LH: err=%0d wen=%0d instret=%0d", bus.err_o, bus.rf_wr_en_o, bus.instret_o);
        check("mis_err",     {31'b0, bus.err_o},        32'd1);
        check("mis_wen",     {31'b0, bus.rf_wr_en_o},   32'd0);
        check("mis_ready",   {31'b0, bus.ex_ready_o},   32'd1);
        check("mis_pend",    {31'b0, bus.pend_valid_o}, 32'd0);
        check("mis_instret", bus.instret_o,             32'd12);

        // Stray response while idle.
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_data_i  = 32'hA5A5A5A5;
        @(negedge clk);
        bus.mem_rsp_valid_i = 1'b0;
        $display("stray rsp: err=%0d wen=%0d", bus.err_o, bus.rf_wr_en_o);
        check("stray_err", {31'b0, bus.err_o},      32'd1);
        check("stray_wen", {31'b0, bus.rf_wr_en_o}, 32'd0);
        check("stray_instret", bus.instret_o,       32'd12);

        // Reset one cycle after a legal load is accepted; the late response is stray.
        drive_op(1'b1, 5'd11, 1'b1, 2'b10, 1'b0, 2'b00, 32'h0);
        @(negedge clk);
        bus.ex_valid_i = 1'b0;
        check("rl_pend_before", {31'b0, bus.pend_valid_o}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rl_pend_reset", {31'b0, bus.pend_valid_o}, 32'd0);
        check("rl_err_reset",  {31'b0, bus.err_o},        32'd0);
        check("rl_ready",      {31'b0, bus.ex_ready_o},   32'd1);
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_data_i  = 32'h11223344;
        @(negedge clk);
        bus.mem_rsp_valid_i = 1'b0;
        $display("reset mid-load: wen=%0d pend=%0d instret=%0d err=%0d",
                 bus.rf_wr_en_o, bus.pend_valid_o, bus.instret_o, bus.err_o);
        check("rl_wen",     {31'b0, bus.rf_wr_en_o},   32'd0);
        check("rl_pend",    {31'b0, bus.pend_valid_o}, 32'd0);
        check("rl_instret", bus.instret_o,             32'd0);
        check("rl_err",     {31'b0, bus.err_o},        32'd1);
        check("rl_data",    bus.rf_wr_data_o,          32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
